// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the CPU (priority)
// and a DMA/loader port, with a bounded-starvation turn for the DMA.
module mem_arbiter #(
   parameter int unsigned AW          = 9,
   parameter int unsigned DW          = 16,
   parameter int unsigned MAX_CPU_RUN = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_mem_cmd,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_wait,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int unsigned CW = 4;

   typedef enum logic {
      CPU_PRI  = 1'b0,
      DMA_TURN = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   arb_state_t    state, state_nxt;
   logic [CW-1:0] run_cnt, run_cnt_nxt;
   owner_t        rd_owner, rd_owner_nxt;
   logic [DW-1:0] cpu_rdata_hold;
   logic          cpu_req, cpu_rd, cpu_wr;
   logic          gnt_cpu, gnt_dma;

   // Grant decision; everything is forced idle while reset is held low.
   always_comb begin
      cpu_rd  = (cpu_mem_cmd == 2'b01);
      cpu_wr  = (cpu_mem_cmd == 2'b10);
      cpu_req = reset & (cpu_rd | cpu_wr);
      gnt_cpu = 1'b0;
      gnt_dma = 1'b0;
      if (reset) begin
         if (state == DMA_TURN && dma_req) gnt_dma = 1'b1;
         else if (cpu_req)                 gnt_cpu = 1'b1;
         else if (dma_req)                 gnt_dma = 1'b1;
      end
   end

   // Next arbitration state, starvation counter and read-return owner.
   always_comb begin
      state_nxt    = CPU_PRI;
      run_cnt_nxt  = '0;
      rd_owner_nxt = OWN_NONE;
      if (state == CPU_PRI && gnt_cpu && dma_req) begin
         run_cnt_nxt = run_cnt + CW'(1);
         if (run_cnt_nxt == CW'(MAX_CPU_RUN)) state_nxt = DMA_TURN;
      end
      if (gnt_cpu && cpu_rd)       rd_owner_nxt = OWN_CPU;
      else if (gnt_dma && !dma_we) rd_owner_nxt = OWN_DMA;
   end

   // RAM drive and requester-facing outputs.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      if (gnt_cpu) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we    = cpu_wr;
      end else if (gnt_dma) begin
         ram_addr  = dma_addr;
         ram_wdata = dma_wdata;
         ram_we    = dma_we;
      end
      cpu_wait   = cpu_req & ~gnt_cpu;
      dma_gnt    = gnt_dma;
      cpu_rdata  = (rd_owner == OWN_CPU) ? ram_rdata : cpu_rdata_hold;
      dma_rvalid = (rd_owner == OWN_DMA);
      dma_rdata  = ram_rdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= CPU_PRI;
         run_cnt        <= '0;
         rd_owner       <= OWN_NONE;
         cpu_rdata_hold <= '0;
      end else begin
         state    <= state_nxt;
         run_cnt  <= run_cnt_nxt;
         rd_owner <= rd_owner_nxt;
         if (rd_owner == OWN_CPU) cpu_rdata_hold <= ram_rdata;
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port synchronous data/instruction RAM between the CPU memory interface (the controller's `mem_cmd`/address path) and a second requester, the DMA/loader port. The CPU has priority; the DMA port fills idle cycles. A starvation counter guarantees the DMA one slot after `MAX_CPU_RUN` consecutive CPU wins. Sits between the CPU address/data muxing and the RAM instance.

## Interface
- `AW`, 9, address width
- `DW`, 16, data width
- `MAX_CPU_RUN`, 4, consecutive CPU grants allowed while DMA is pending; legal range 1..15
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `cpu_mem_cmd`  in  2  00 none, 01 read, 10 write; 11 is treated as none
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_wait`  out  1  CPU request not serviced this cycle; CPU holds cmd, addr and data
- `cpu_rdata`  out  DW  CPU read data, held
- `dma_req`  in  1  DMA access request; fields stable until `dma_gnt`
- `dma_we`  in  1  1 = write, 0 = read
- `dma_addr`  in  AW  DMA address
- `dma_wdata`  in  DW  DMA write data
- `dma_gnt`  out  1  DMA access performed this cycle
- `dma_rvalid`  out  1  `dma_rdata` valid (one cycle after a granted DMA read)
- `dma_rdata`  out  DW  DMA read data
- `ram_addr`  out  AW  to RAM
- `ram_we`  out  1  to RAM
- `ram_wdata`  out  DW  to RAM
- `ram_rdata`  in  DW  from RAM; valid the cycle after the address is presented

## Operation
- Arbitration state: `CPU_PRI` (default) and `DMA_TURN`; 4-bit `run_cnt`.
- CPU request means `cpu_mem_cmd` is 01 or 10.
- In `CPU_PRI`:
  - CPU request → CPU granted.
  - Otherwise, `dma_req` → DMA granted.
  - Otherwise, no grant.
- In `DMA_TURN`:
  - `dma_req` → DMA granted, and a CPU request that cycle gets `cpu_wait`=1.
  - No `dma_req` → behaves as `CPU_PRI`.
  - Next state is always `CPU_PRI`, with `run_cnt` cleared.
- `run_cnt` update in `CPU_PRI`:
  - Increments when the CPU is granted and `dma_req`=1.
  - Clears when DMA is granted or `dma_req`=0.
  - When the increment reaches `MAX_CPU_RUN`, the next state is `DMA_TURN`.
- RAM port, combinational from the granted side:
  - `ram_addr` and `ram_wdata` come from the granted requester.
  - `ram_we`=1 only for a granted write.
  - No grant → `ram_addr`=0, `ram_wdata`=0, `ram_we`=0.
- `cpu_wait` = CPU request AND NOT CPU granted (combinational).
- `dma_gnt` = DMA granted (combinational, same cycle as `dma_req`). The DMA may keep `dma_req` high with new fields for back-to-back accesses.
- Read return tracking: a 2-bit registered `rd_owner` (none/CPU/DMA) records the owner of the granted read.
  - Return cycle owned by CPU: `cpu_rdata` = `ram_rdata`, and `cpu_rdata_hold` ← `ram_rdata`.
  - Otherwise: `cpu_rdata` = `cpu_rdata_hold`.
  - `dma_rvalid` = (`rd_owner`==DMA). `dma_rdata` = `ram_rdata`, meaningful only when `dma_rvalid`=1.

## Timing
- Grants and RAM drive are combinational in the request cycle T.
- Read data appears at T+1, for both requesters.
- `cpu_rdata` holds its value from T+1 until the next CPU read return, and is unaffected by intervening DMA reads.
- Writes complete at the end of cycle T.
- Maximum DMA wait with CPU saturating: `MAX_CPU_RUN` cycles. Maximum added CPU stall per DMA turn: 1 cycle.
- While `reset`=0:
  - State = `CPU_PRI`, `run_cnt`=0, `rd_owner`=none, `cpu_rdata_hold`=0.
  - Forced outputs: `cpu_wait`=0, `dma_gnt`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `dma_rvalid`=0, `cpu_rdata`=0.
- Reset mid-read discards the pending return: no `dma_rvalid` after release.
- Release is asynchronous-assert and synchronous-deassert, via the top-level synchronizer; the first arbitration happens on the first cycle after release.

## Test plan
- **Reset:** hold `reset`=0 while driving `cpu_mem_cmd`=01 and `dma_req`=1 → all outputs 0. After release, no `dma_rvalid` until a DMA read is granted.
- **CPU read alone:**
  - Setup: RAM[5]=16'hABCD; CPU reads address 5 at T.
  - At T: `ram_addr`=5, `cpu_wait`=0.
  - At T+1: `cpu_rdata`=16'hABCD, which stays ABCD for 3 further idle cycles.
- **DMA fill with CPU idle:**
  - DMA write, address 3, data 16'h1234 → `dma_gnt`=1 and `ram_we`=1 in the same cycle.
  - Following DMA read of address 3 → `dma_rvalid`=1 next cycle with `dma_rdata`=16'h1234.
- **Starvation bound:**
  - Setup: `MAX_CPU_RUN`=4; CPU reads every cycle; `dma_req`=1 from cycle 0.
  - CPU granted in cycles 0–3.
  - Cycle 4: `dma_gnt`=1 and `cpu_wait`=1.
  - Cycle 5: CPU granted again. The pattern repeats with period 5.
- **Read hold across DMA:**
  - Setup: RAM[7]=16'h00AA, RAM[8]=16'h00BB. CPU reads 7 at T; DMA reads 8 at T+1 with the CPU idle.
  - At T+2: `dma_rdata`=16'h00BB, `dma_rvalid`=1, and `cpu_rdata` is still 16'h00AA.
- **Reset mid-operation:** assert `reset`=0 in the cycle after a granted DMA read → `dma_rvalid`=0. After release, the first DMA-pending CPU run counts again from 0.
